// File: rtl/ff256_ct_seq_byte_packer_pkg.sv
// Shared constants and types for the sequential FF(256) cosine-transform path.
// Byte, word and lane-index widths used by the mux and the packer.
package ff256_ct_seq_pkg;

  localparam int BYTE_W  = 8;
  localparam int N_BYTES = 8;
  localparam int WORD_W  = BYTE_W * N_BYTES;
  localparam int IDX_W   = $clog2(N_BYTES);

  typedef logic [BYTE_W-1:0] gf_byte_t;
  typedef logic [WORD_W-1:0] gf_word_t;
  typedef logic [IDX_W-1:0]  byte_idx_t;

endpackage

// File: rtl/ff256_ct_seq_byte_packer_if.sv
// Byte-in / word-out handshake bundle around the FF(256) byte packer.
// slave = packer side, master = producer/consumer side.
interface ff256_ct_seq_byte_packer_if;
  import ff256_ct_seq_pkg::*;

  logic      in_valid;
  logic      in_ready;
  gf_byte_t  in_data;
  byte_idx_t byte_idx;
  logic      out_valid;
  logic      out_ready;
  gf_word_t  out_word;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, byte_idx, out_valid, out_word
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, byte_idx, out_valid, out_word
  );

endinterface

// File: rtl/ff256_ct_seq_byte_packer.sv
// Packs a serial GF(256) byte stream into 64-bit words, driving the
// upstream mux selector; assembly + output register for full rate.
module ff256_ct_seq_byte_packer
  import ff256_ct_seq_pkg::*;
#(
  parameter int P_BYTE_W  = BYTE_W,
  parameter int P_N_BYTES = N_BYTES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  ff256_ct_seq_byte_packer_if.slave bus
);

  localparam int P_WORD_W = P_BYTE_W * P_N_BYTES;
  localparam int P_IDX_W  = $clog2(P_N_BYTES);

  logic [P_IDX_W-1:0]  idx_q, idx_d;
  logic [P_WORD_W-1:0] asm_q, asm_d;
  logic [P_WORD_W-1:0] word_q, word_d;
  logic                vld_q, vld_d;
  logic [P_WORD_W-1:0] merged;
  logic                last;
  logic                ready;
  logic                acc;

  assign last  = idx_q == P_IDX_W'(P_N_BYTES - 1);
  // Only the final byte can stall: it needs the output register free.
  assign ready = ~(last & vld_q & ~bus.out_ready);
  assign acc   = bus.in_valid & ready;

  always_comb begin
    merged = asm_q;
    merged[idx_q*P_BYTE_W +: P_BYTE_W] = bus.in_data;
    idx_d  = idx_q;
    asm_d  = asm_q;
    word_d = word_q;
    vld_d  = vld_q;
    if (vld_q & bus.out_ready) begin
      vld_d = 1'b0;
    end
    if (clear) begin
      idx_d = '0;
      asm_d = '0;
    end else if (acc) begin
      if (last) begin
        word_d = merged;
        vld_d  = 1'b1;
        idx_d  = '0;
        asm_d  = '0;
      end else begin
        asm_d = merged;
        idx_d = idx_q + P_IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      asm_q  <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      asm_q  <= asm_d;
      word_q <= word_d;
      vld_q  <= vld_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.byte_idx  = byte_idx_t'(idx_q);
  assign bus.out_valid = vld_q;
  assign bus.out_word  = gf_word_t'(word_q);

endmodule

// File: tb/tb_ff256_ct_seq_byte_packer.sv
// Randomised self-checking bench for the FF(256) byte packer against a
// queue-based model of word assembly and the single output slot.
module tb_ff256_ct_seq_byte_packer;
  import ff256_ct_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic clear;

  ff256_ct_seq_byte_packer_if bus();

  ff256_ct_seq_byte_packer dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  gf_byte_t cur[$];
  logic     pend;
  gf_word_t mword;
  int       nwords;
  int       drains;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle, check DUT against model, then advance the model.
  task automatic step(input logic v, input logic [7:0] d,
                      input logic ordy, input logic clr);
    logic     exp_rdy;
    logic     done;
    gf_word_t w;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    clear         = clr;
    #1;
    exp_rdy = !(cur.size() == N_BYTES - 1 && pend && !ordy);
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    chk("byte_idx", 64'(bus.byte_idx), 64'(cur.size()));
    chk("out_valid", 64'(bus.out_valid), 64'(pend));
    chk("out_word", bus.out_word, mword);
    if (bus.out_valid && ordy) drains++;
    done = 1'b0;
    if (clr) begin
      cur.delete();
    end else if (v && exp_rdy) begin
      cur.push_back(d);
      if (cur.size() == N_BYTES) begin
        w = '0;
        for (int i = 0; i < N_BYTES; i++) w[8*i +: 8] = cur[i];
        mword = w;
        cur.delete();
        nwords++;
        done = 1'b1;
      end
    end
    if (done) pend = 1'b1;
    else if (pend && ordy) pend = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'hEE;
    bus.out_ready = 1'b0;
    clear = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cur.delete();
    pend = 1'b0;
    mword = '0;
  endtask

  initial begin
    int w0, budget, t, c0;
    nwords = 0;
    drains = 0;
    do_reset(2);

    // reset mid-word
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hA0 + i), 1'b1, 1'b0);
    chk("pre_rst_idx", 64'(bus.byte_idx), 64'd5);
    do_reset(2);
    chk("rst_idx", 64'(bus.byte_idx), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_word", bus.out_word, 64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd1);

    // basic pack
    for (int i = 0; i < 8; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
    chk("basic_valid", 64'(bus.out_valid), 64'd1);
    chk("basic_word", bus.out_word, 64'h0706050403020100);
    chk("basic_idx", 64'(bus.byte_idx), 64'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // backpressure
    for (int i = 0; i < 8; i++) step(1'b1, 8'h11, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'hB7, 1'b0, 1'b0);
    chk("bp_held", bus.out_word, 64'h1111111111111111);
    step(1'b1, 8'hB7, 1'b1, 1'b0);
    chk("bp_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_word", bus.out_word, 64'hB7B6B5B4B3B2B1B0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // gapped random traffic
    w0 = nwords;
    budget = 4000;
    t = 0;
    while (nwords - w0 < 100 && t < budget) begin
      step(1'($urandom_range(0, 1)), 8'($urandom),
           1'($urandom_range(0, 9) < 7), 1'b0);
      t++;
    end
    chk("gap_words", 64'(nwords - w0), 64'd100);
    for (int i = 0; i < 2; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // clear with pending word
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    step(1'b1, 8'h5F, 1'b0, 1'b1);
    chk("clr_idx", 64'(bus.byte_idx), 64'd0);
    chk("clr_pend", bus.out_word, 64'h4746454443424140);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
    chk("clr_word", bus.out_word, 64'hC7C6C5C4C3C2C1C0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // full throughput
    c0 = nwords;
    drains = 0;
    for (int i = 0; i < 64; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("tput_model", 64'(nwords - c0), 64'd8);
    chk("tput_drains", 64'(drains), 64'd8);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
